// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mult
//  Description : Sequential shift-and-add multiplier, one partial product per
//                clock, selectable unsigned or two's-complement signed mode.
//                Three-state controller (IDLE / RUN / DONE); the product
//                register is loaded only when a run completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic                   START,
    input  logic                   SGN,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    output logic [2*WIDTH-1:0]     P,
    output logic                   BUSY,
    output logic                   READY
);

    // Counter holds 0..WIDTH-1 during a run; sized for WIDTH+1 values so the
    // comparison against the last step never needs a wrap.
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;

    // Captured operands: multiplicand, mode, and the multiplier, which lives
    // in the low half of the accumulator and is shifted out LSB first.
    logic [WIDTH-1:0] mcand;
    logic             sgn_mode;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] step_cnt;

    logic             last_step;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    assign last_step = (step_cnt == LAST_STEP);

    // State register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: START wins over everything, including completion.
    always_comb begin
        state_next = state;
        if (START) begin
            state_next = S_RUN;
        end else begin
            case (state)
                S_RUN:   state_next = last_step ? S_DONE : S_RUN;
                S_DONE:  state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded directly from the state; mutually exclusive.
    always_comb begin
        BUSY  = (state == S_RUN);
        READY = (state == S_DONE);
    end

    // One add/subtract-and-shift step. The W+1 bit adder keeps the carry in
    // unsigned mode and the true sign in signed mode (e.g. 0 - (-2^(W-1))).
    // The multiplier MSB carries negative weight in signed mode, hence the
    // subtraction on the final step.
    always_comb begin
        mcand_ext = {sgn_mode & mcand[WIDTH-1], mcand};
        hi_ext    = {sgn_mode & acc_hi[WIDTH-1], acc_hi};
        sum       = hi_ext;
        if (acc_lo[0]) begin
            if (sgn_mode && last_step) begin
                sum = hi_ext - mcand_ext;
            end else begin
                sum = hi_ext + mcand_ext;
            end
        end
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    end

    // Datapath registers: capture on START, step while running, publish the
    // product only on the step that completes the run.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            mcand    <= '0;
            sgn_mode <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            step_cnt <= '0;
            P        <= '0;
        end else if (START) begin
            mcand    <= A;
            sgn_mode <= SGN;
            acc_hi   <= '0;
            acc_lo   <= B;
            step_cnt <= '0;
        end else if (state == S_RUN) begin
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            if (last_step) begin
                P <= {hi_next, lo_next};
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mult
//  Description : Self-checking bench for shift_add_mult at WIDTH=4 and 8:
//                directed vector tables, multi-cycle corner sequences and
//                randomized operands against an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

    logic        CK = 1'b0;
    logic        RN;
    logic        st4, sg4, busy4, rdy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        st8, sg8, busy8, rdy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int passed = 0;
    int total  = 0;
    logic [7:0]  prev4;
    logic [15:0] prev8;

    typedef struct {
        logic       sgn;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec4_t;

    typedef struct {
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec8_t;

    vec4_t tab4[8];
    vec8_t tab8[4];

    always #5 CK = ~CK;

    shift_add_mult #(.WIDTH(4)) dut4 (
        .CK(CK), .RN(RN), .START(st4), .SGN(sg4), .A(a4), .B(b4),
        .P(p4), .BUSY(busy4), .READY(rdy4)
    );

    shift_add_mult #(.WIDTH(8)) dut8 (
        .CK(CK), .RN(RN), .START(st8), .SGN(sg8), .A(a8), .B(b8),
        .P(p8), .BUSY(busy8), .READY(rdy8)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    // Reference: plain integer multiplication, truncated to 2*W bits.
    function automatic logic [7:0] model4(input logic sgn, input logic [3:0] a, input logic [3:0] b);
        int x, y;
        x = sgn ? int'($signed(a)) : int'(a);
        y = sgn ? int'($signed(b)) : int'(b);
        return 8'(x * y);
    endfunction

    function automatic logic [15:0] model8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = sgn ? int'($signed(a)) : int'(a);
        y = sgn ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    // Full run: START at edge 0, RUN with old P through edge W-1, DONE at W.
    // Operands are scrambled after capture to show they are not re-sampled.
    task automatic run4(input string nm, input logic sgn, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp);
        @(negedge CK);
        st4 = 1'b1; sg4 = sgn; a4 = a; b4 = b;
        for (int e = 0; e <= 4; e++) begin
            @(posedge CK); #1;
            if (e == 0) begin
                st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
            end
            chk({nm, "_excl"}, 16'(busy4 & rdy4), 16'd0);
            if (e < 4) begin
                chk({nm, "_busy"}, 16'(busy4), 16'd1);
                chk({nm, "_p_hold"}, 16'(p4), 16'(prev4));
            end else begin
                chk({nm, "_ready"}, 16'(rdy4), 16'd1);
                chk({nm, "_p"}, 16'(p4), 16'(exp));
            end
        end
        prev4 = exp;
    endtask

    task automatic run8(input string nm, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
        @(negedge CK);
        st8 = 1'b1; sg8 = sgn; a8 = a; b8 = b;
        for (int e = 0; e <= 8; e++) begin
            @(posedge CK); #1;
            if (e == 0) begin
                st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
            end
            if (e < 8) begin
                chk({nm, "_busy"}, 16'(busy8), 16'd1);
                chk({nm, "_p_hold"}, p8, prev8);
            end else begin
                chk({nm, "_ready"}, 16'(rdy8), 16'd1);
                chk({nm, "_busy_off"}, 16'(busy8), 16'd0);
                chk({nm, "_p"}, p8, exp);
            end
        end
        prev8 = exp;
    endtask

    initial begin
        logic       rs;
        logic [3:0] ra, rb;
        logic [7:0] ra8, rb8;

        tab4[0] = '{1'b0, 4'hF, 4'hF, 8'hE1};
        tab4[1] = '{1'b0, 4'h0, 4'h9, 8'h00};   // START in DONE with P=E1
        tab4[2] = '{1'b1, 4'h8, 4'h8, 8'h40};
        tab4[3] = '{1'b1, 4'hF, 4'h7, 8'hF9};
        tab4[4] = '{1'b1, 4'h8, 4'h7, 8'hC8};
        tab4[5] = '{1'b1, 4'h7, 4'h8, 8'hC8};
        tab4[6] = '{1'b1, 4'hF, 4'hF, 8'h01};
        tab4[7] = '{1'b0, 4'h8, 4'h8, 8'h40};
        tab8[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tab8[1] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        tab8[2] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tab8[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};

        RN = 1'b0; st4 = 0; sg4 = 0; a4 = 0; b4 = 0;
        st8 = 0; sg8 = 0; a8 = 0; b8 = 0;
        prev4 = '0; prev8 = '0;
        repeat (2) @(posedge CK);
        #1;
        chk("rst_p", 16'(p4), 16'd0);
        chk("rst_busy", 16'(busy4), 16'd0);
        chk("rst_ready", 16'(rdy4), 16'd0);
        chk("rst_p8", p8, 16'd0);

        // START honoured on the first edge after release; 3*5 aborted at edge 2 by 2*2.
        @(negedge CK);
        RN = 1'b1; st4 = 1'b1; sg4 = 0; a4 = 4'd3; b4 = 4'd5;
        for (int e = 0; e <= 6; e++) begin
            @(posedge CK); #1;
            if (e == 0) st4 = 1'b0;
            if (e == 1) begin st4 = 1'b1; a4 = 4'd2; b4 = 4'd2; end
            if (e == 2) st4 = 1'b0;
            if (e < 6) begin
                chk("abort_busy", 16'(busy4), 16'd1);
                chk("abort_noready", 16'(rdy4), 16'd0);
                chk("abort_p", 16'(p4), 16'd0);
            end else begin
                chk("abort_ready", 16'(rdy4), 16'd1);
                chk("abort_p_final", 16'(p4), 16'h04);
            end
        end
        prev4 = 8'h04;

        for (int i = 0; i < 8; i++)
            run4($sformatf("tab4_%0d", i), tab4[i].sgn, tab4[i].a, tab4[i].b, tab4[i].p);

        // START on the completing edge keeps RUN and leaves P untouched.
        @(negedge CK);
        st4 = 1'b1; sg4 = 0; a4 = 4'd7; b4 = 4'd3;
        for (int e = 0; e <= 8; e++) begin
            @(posedge CK); #1;
            if (e == 0) st4 = 1'b0;
            if (e == 3) begin st4 = 1'b1; a4 = 4'd6; b4 = 4'd5; end
            if (e == 4) st4 = 1'b0;
            if (e < 8) begin
                chk("late_busy", 16'(busy4), 16'd1);
                chk("late_noready", 16'(rdy4), 16'd0);
                chk("late_p_hold", 16'(p4), 16'(prev4));
            end else begin
                chk("late_ready", 16'(rdy4), 16'd1);
                chk("late_p", 16'(p4), 16'h1E);
            end
        end
        prev4 = 8'h1E;

        // Asynchronous reset mid-run: outputs clear at once, no READY afterwards.
        @(negedge CK);
        st4 = 1'b1; sg4 = 0; a4 = 4'd5; b4 = 4'd5;
        @(posedge CK); #1; st4 = 1'b0;
        repeat (2) @(posedge CK);
        #2; RN = 1'b0; #1;
        chk("arst_p", 16'(p4), 16'd0);
        chk("arst_busy", 16'(busy4), 16'd0);
        chk("arst_ready", 16'(rdy4), 16'd0);
        @(negedge CK); RN = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge CK); #1;
            chk("arst_quiet_ready", 16'(rdy4), 16'd0);
            chk("arst_quiet_busy", 16'(busy4), 16'd0);
        end
        prev4 = '0; prev8 = '0;

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom); ra = 4'($urandom); rb = 4'($urandom);
            run4($sformatf("rnd4_%0d", i), rs, ra, rb, model4(rs, ra, rb));
        end

        for (int i = 0; i < 4; i++)
            run8($sformatf("tab8_%0d", i), tab8[i].sgn, tab8[i].a, tab8[i].b, tab8[i].p);

        for (int i = 0; i < 15; i++) begin
            rs = 1'($urandom); ra8 = 8'($urandom); rb8 = 8'($urandom);
            run8($sformatf("rnd8_%0d", i), rs, ra8, rb8, model8(rs, ra8, rb8));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port CK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RN, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port START, input, 1 bit: begin a multiplication with the current operands.
REQ-005 The block SHALL have port SGN, input, 1 bit: mode, sampled with START; 0 = unsigned, 1 = two's-complement signed.
REQ-006 The block SHALL have port A, input, WIDTH bits: multiplicand.
REQ-007 The block SHALL have port B, input, WIDTH bits: multiplier.
REQ-008 The block SHALL have port P, output, 2*WIDTH bits: product register.
REQ-009 The block SHALL have port BUSY, output, 1 bit: multiplication in progress.
REQ-010 The block SHALL have port READY, output, 1 bit: P holds a valid completed product.

Function
REQ-011 The block SHALL implement a three-state controller: IDLE, RUN, DONE.
REQ-012 When START=1 at an edge, in any state, the block SHALL do all of the following on that edge:
- capture A, B and SGN into internal registers;
- clear the accumulator and the step counter;
- enter RUN.
REQ-013 In RUN, the block SHALL perform exactly one add-shift step per edge, consuming multiplier bits LSB first, for WIDTH steps.
REQ-014 In each step, if the current multiplier bit is 1, the block SHALL add the captured multiplicand into the upper accumulator half, then arithmetic- or logical-shift right by 1 per the SGN mode.
REQ-015 With SGN=1, the block SHALL treat the multiplicand as sign-extended and SHALL subtract, instead of add, on the final step (multiplier MSB) so that P equals signed(A)*signed(B).
REQ-016 With SGN=0, P SHALL equal unsigned(A)*unsigned(B).
REQ-017 The adder SHALL be WIDTH+1 bits wide so that no carry or sign information is lost in either mode.
REQ-018 The step counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap inside a run.
REQ-019 Latency: with START sampled at edge 0, the last step SHALL occur at edge WIDTH, the block SHALL enter DONE at that edge, and READY SHALL be 1 from that edge until the next START or reset.
REQ-020 P SHALL be updated only on the edge that enters DONE; during RUN, P SHALL retain its previous value.
REQ-021 BUSY SHALL be 1 exactly while in RUN.
REQ-022 READY SHALL be 1 exactly while in DONE.
REQ-023 BUSY and READY SHALL never both be 1.
REQ-024 START during RUN SHALL abort the current operation and restart with new operands, with no READY pulse for the aborted operation.
REQ-025 START on the same edge RUN would enter DONE SHALL take priority: the controller stays in RUN, READY stays 0, and P is not updated.
REQ-026 START in DONE SHALL drop READY on that edge; P SHALL keep the old product until the new result is written.
REQ-027 Changes on A, B or SGN while not sampling START SHALL have no effect.
REQ-028 Operand values 0, all-ones and the most negative signed value SHALL produce correct products with no special-case handling visible at the ports.

Reset
REQ-029 When RN=0, the block SHALL asynchronously force IDLE, P=0, BUSY=0, READY=0, and clear all internal registers, regardless of the clock.
REQ-030 Reset asserted mid-RUN SHALL discard the operation; no READY SHALL follow reset release without a new START.
REQ-031 After RN rises, START SHALL be honoured from the first rising edge of CK at which RN is sampled high.

Verification
REQ-032 WIDTH=4, SGN=0, A=15, B=15, START at edge 0 -> BUSY=1 on edges 1..3, READY=1 and P=0xE1 from edge 4.
REQ-033 WIDTH=4, SGN=1, A=0x8, B=0x8 (-8*-8) -> P=0x40; A=0xF, B=0x7 (-1*7) -> P=0xF9.
REQ-034 WIDTH=4: START(3*5), then START(2*2) at edge 2 -> no READY at edge 4, READY at edge 6 with P=0x04; P=0x00 (reset value) until edge 6.
REQ-035 WIDTH=4: RN low at edge 2 of a run -> P=0, BUSY=0, READY=0 immediately; READY stays 0 with no further START.
REQ-036 WIDTH=8, SGN=0, A=255, B=255 -> P=0xFE01 at edge 8; SGN=1, A=0x80, B=0x7F -> P=0xC080.
REQ-037 WIDTH=4: in DONE with P=0xE1, START(A=0, B=9) -> READY falls on that edge, P stays 0xE1 for 3 cycles, then P=0x00 with READY=1.
